// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction memory request bus and decode handshake for instr_fetch_unit
interface instr_fetch_unit_if;
    logic [31:0] MEM_addr;
    logic        rMEM_en;
    logic [31:0] MEM_dout;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    modport master (
        output MEM_addr, rMEM_en, inst_valid, inst_data, inst_pc,
        input  MEM_dout, inst_ready
    );

    modport slave (
        input  MEM_addr, rMEM_en, inst_valid, inst_data, inst_pc,
        output MEM_dout, inst_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC, word fetch issue, 2-entry decode buffer, redirect flush
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_CHK_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] MAX_ADDR = 32'h0000_0F9C
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   fetch_en,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    output logic                   fetch_err,
    instr_fetch_unit_if.master     bus
);

    logic [31:0] pc;
    logic [31:0] req_pc;
    logic [1:0]  count;
    logic        inflight;
    logic        kill;
    logic        err_stop;
    logic [31:0] buf_data [2];
    logic [31:0] buf_pc   [2];

    logic        pop;
    logic        push;
    logic        issue;
    logic [2:0]  occupancy;
    logic [31:0] target_pc;
    logic [31:0] seq_pc;

`ifdef FETCH_MISALIGN_CHK_EN
    assign target_pc = redirect_pc;

    // Any redirect re-evaluates the trap, so an aligned one releases it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            err_stop <= 1'b0;
        end else if (redirect_valid) begin
            err_stop <= |redirect_pc[1:0];
        end
    end

    assign fetch_err = err_stop;
`else
    assign target_pc = redirect_pc & 32'hFFFF_FFFC;
    assign err_stop  = 1'b0;
    assign fetch_err = 1'b0;
`endif

    assign bus.inst_valid = (count != 2'd0);
    assign bus.inst_data  = bus.inst_valid ? buf_data[0] : 32'd0;
    assign bus.inst_pc    = bus.inst_valid ? buf_pc[0]   : 32'd0;
    assign bus.MEM_addr   = pc;

    assign pop       = bus.inst_valid & bus.inst_ready;
    // Entries held plus the one on its way must leave room for a new response.
    assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign issue     = resetn & fetch_en & ~redirect_valid & ~err_stop & (occupancy < 3'd2);
    assign push      = inflight & ~kill & ~redirect_valid;
    assign seq_pc    = (pc == MAX_ADDR) ? RESET_PC : pc + 32'd4;

    assign bus.rMEM_en = issue;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pc       <= RESET_PC;
            req_pc   <= RESET_PC;
            count    <= 2'd0;
            inflight <= 1'b0;
            kill     <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                req_pc <= pc;
            end
            if (redirect_valid) begin
                pc    <= target_pc;
                count <= 2'd0;
                kill  <= issue;
            end else begin
                if (issue) begin
                    pc <= seq_pc;
                end
                if (inflight) begin
                    kill <= 1'b0;
                end
                // Entry 0 is always the head; entry 1 shifts down on a pop.
                case ({push, pop})
                    2'b10: begin
                        buf_data[count[0]] <= bus.MEM_dout;
                        buf_pc[count[0]]   <= req_pc;
                        count              <= count + 2'd1;
                    end
                    2'b01: begin
                        buf_data[0] <= buf_data[1];
                        buf_pc[0]   <= buf_pc[1];
                        count       <= count - 2'd1;
                    end
                    2'b11: begin
                        if (count == 2'd1) begin
                            buf_data[0] <= bus.MEM_dout;
                            buf_pc[0]   <= req_pc;
                        end else begin
                            buf_data[0] <= buf_data[1];
                            buf_pc[0]   <= buf_pc[1];
                            buf_data[1] <= bus.MEM_dout;
                            buf_pc[1]   <= req_pc;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit with MAX_ADDR = 0x0C
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_err;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_iss [$];
    logic [31:0] exp_pc  [$];

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .MAX_ADDR (32'h0000_000C)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_err      (fetch_err),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h0:   return 32'h0000_0013;
            32'h4:   return 32'h0010_0093;
            32'h8:   return 32'h0010_8093;
            32'hC:   return 32'h0010_0073;
            default: return 32'hC0DE_0000 | addr;
        endcase
    endfunction

    always @(posedge clk) begin
        if (bus.rMEM_en) begin
            bus.MEM_dout <= mem_word(bus.MEM_addr);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every request and every accepted instruction is matched in order.
    always @(negedge clk) begin
        if (resetn === 1'b1 && bus.rMEM_en === 1'b1) begin
            if (exp_iss.size() == 0) begin
                chk("unexpected_req", bus.MEM_addr, 32'hFFFF_FFFF);
            end else begin
                chk("req_addr", bus.MEM_addr, exp_iss.pop_front());
            end
        end
        if (resetn === 1'b1 && bus.inst_valid === 1'b1 && bus.inst_ready === 1'b1) begin
            if (exp_pc.size() == 0) begin
                chk("unexpected_inst", bus.inst_pc, 32'hFFFF_FFFF);
            end else begin
                logic [31:0] p;
                p = exp_pc.pop_front();
                chk("inst_pc", bus.inst_pc, p);
                chk("inst_data", bus.inst_data, mem_word(p));
            end
        end
    end

    initial begin
        resetn         = 1'b0;
        fetch_en       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        bus.inst_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
        chk("rst_rmem_en",    {31'd0, bus.rMEM_en},    32'd0);
        chk("rst_mem_addr",   bus.MEM_addr,            32'd0);
        chk("rst_inst_data",  bus.inst_data,           32'd0);
        chk("rst_inst_pc",    bus.inst_pc,             32'd0);
        chk("rst_fetch_err",  {31'd0, fetch_err},      32'd0);

        for (int c = 0; c < 53; c++) begin
            @(posedge clk);
            #1;
            resetn         = (c != 35);
            fetch_en       = (c < 46);
            bus.inst_ready = !((c >= 6 && c <= 11) || (c >= 33 && c <= 35));
            redirect_valid = (c == 17) || (c == 23) || (c == 27);
            redirect_pc    = (c == 17) ? 32'h40 : (c == 23) ? 32'h42 : (c == 27) ? 32'h80 : 32'h0;

            if (c == 0) begin
                for (int i = 0; i < 11; i++) exp_iss.push_back(32'((i % 4) * 4));
                for (int i = 0; i < 10; i++) exp_pc.push_back(32'((i % 4) * 4));
            end
            if (c == 17) begin
                for (int i = 0; i < 5; i++) exp_iss.push_back(32'h40 + 32'(i * 4));
                for (int i = 0; i < 4; i++) exp_pc.push_back(32'h40 + 32'(i * 4));
            end
`ifndef FETCH_MISALIGN_CHK_EN
            if (c == 23) begin
                for (int i = 0; i < 3; i++) exp_iss.push_back(32'h40 + 32'(i * 4));
                for (int i = 0; i < 2; i++) exp_pc.push_back(32'h40 + 32'(i * 4));
            end
`endif
            if (c == 27) begin
                for (int i = 0; i < 5; i++) exp_iss.push_back(32'h80 + 32'(i * 4));
                for (int i = 0; i < 3; i++) exp_pc.push_back(32'h80 + 32'(i * 4));
            end
            if (c == 35) begin
                for (int i = 0; i < 10; i++) exp_iss.push_back(32'((i % 4) * 4));
                for (int i = 0; i < 10; i++) exp_pc.push_back(32'((i % 4) * 4));
            end

            @(negedge clk);
            if (c == 0 || c == 1) chk("early_valid", {31'd0, bus.inst_valid}, 32'd0);
            if (c == 2) begin
                chk("first_valid", {31'd0, bus.inst_valid}, 32'd1);
                chk("first_pc",    bus.inst_pc,             32'h0);
                chk("first_data",  bus.inst_data,           32'h0000_0013);
            end
            if (c >= 6 && c <= 11) begin
                chk("stall_valid", {31'd0, bus.inst_valid}, 32'd1);
                chk("stall_pc",    bus.inst_pc,             32'h0);
                chk("stall_req",   {31'd0, bus.rMEM_en},    32'd0);
            end
            if (c == 18) chk("redir_addr", bus.MEM_addr, 32'h40);
            if (c == 18 || c == 19) chk("redir_gap_valid", {31'd0, bus.inst_valid}, 32'd0);
            if (c == 20) begin
                chk("redir_valid", {31'd0, bus.inst_valid}, 32'd1);
                chk("redir_pc",    bus.inst_pc,             32'h40);
            end
`ifdef FETCH_MISALIGN_CHK_EN
            if (c >= 24 && c <= 27) begin
                chk("misalign_err", {31'd0, fetch_err},   32'd1);
                chk("misalign_req", {31'd0, bus.rMEM_en}, 32'd0);
            end
            if (c == 28) begin
                chk("realign_err",  {31'd0, fetch_err},   32'd0);
                chk("realign_req",  {31'd0, bus.rMEM_en}, 32'd1);
                chk("realign_addr", bus.MEM_addr,         32'h80);
            end
`else
            if (c >= 24 && c <= 28) chk("no_err", {31'd0, fetch_err}, 32'd0);
            if (c == 26) chk("masked_pc", bus.inst_pc, 32'h40);
`endif
            if (c == 34) begin
                chk("full_valid", {31'd0, bus.inst_valid}, 32'd1);
                chk("full_req",   {31'd0, bus.rMEM_en},    32'd0);
            end
            if (c == 35) chk("rst_cycle_req", {31'd0, bus.rMEM_en}, 32'd0);
            if (c == 36) begin
                chk("post_rst_valid", {31'd0, bus.inst_valid}, 32'd0);
                chk("post_rst_addr",  bus.MEM_addr,            32'h0);
                chk("post_rst_pc",    bus.inst_pc,             32'h0);
            end
        end

        chk("reqs_left",  32'(exp_iss.size()), 32'd0);
        chk("insts_left", 32'(exp_pc.size()),  32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
